// File: rtl/blackjack_pkg.sv
// Shared types and constants for the blackjack card path: card width, deck size,
// requester indices and the dealer controller state set.
package blackjack_pkg;

    localparam int CARD_W     = 6;
    localparam int DECK_SIZE  = 52;
    localparam int REQ_PLAYER = 0;
    localparam int REQ_DEALER = 1;

    typedef enum logic [2:0] {
        IDLE,
        SHUF_REQ,
        SHUF_WAIT,
        READY,
        FETCH,
        LOAD,
        DELIVER
    } dealer_state_t;

    function automatic logic [1:0] req_onehot(input logic idx);
        req_onehot = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: a lone requester wins outright, a tie goes
// to whichever requester was not granted last.
module rr_arbiter2
    import blackjack_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = req[REQ_DEALER];
        if (req == 2'b11) begin
            winner = ~last_grant;
        end
    end

endmodule

// File: rtl/card_dealer_ctrl.sv
// Deals cards from the shuffled deck to player/dealer and sequences reshuffles
// at power-up, on deck exhaustion and at low-deck round boundaries.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | after reset; moves straight on to request a shuffle
//   SHUF_REQ  | single-cycle shuf_start pulse, timeout counter cleared
//   SHUF_WAIT | waiting for shuf_done or the timeout
//   READY     | deck usable; evaluates round start and card requests
//   FETCH     | deck read address presented, waiting for read data
//   LOAD      | read data captured, pointer and count updated
//   DELIVER   | card_valid and grant asserted for this one cycle
module card_dealer_ctrl #(
    parameter int DECK_SIZE     = blackjack_pkg::DECK_SIZE,
    parameter int RESHUF_THRESH = 15,
    parameter int SHUF_TIMEOUT  = 1023
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             new_round,
    input  logic [1:0]                       req,
    output logic [1:0]                       grant,
    output logic                             card_valid,
    output logic [blackjack_pkg::CARD_W-1:0] card_out,
    output logic                             shuf_start,
    input  logic                             shuf_done,
    output logic [blackjack_pkg::CARD_W-1:0] card_addr,
    input  logic [blackjack_pkg::CARD_W-1:0] card_rd_data,
    output logic [blackjack_pkg::CARD_W-1:0] cards_left,
    output logic                             ready,
    output logic                             shuf_err
);
    import blackjack_pkg::*;

    localparam int TMO_W = $clog2(SHUF_TIMEOUT + 1);

    dealer_state_t     state_q, state_d;
    logic [CARD_W-1:0] ptr_q, left_q, addr_q, card_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              pending_q, last_q, winner_q, err_q;
    logic              arb_winner, arb_valid;
    logic              rnd, low_deck, deck_empty, tmo_hit, take;

    rr_arbiter2 u_arb (
        .req        (req),
        .last_grant (last_q),
        .winner     (arb_winner),
        .valid      (arb_valid)
    );

    assign rnd        = new_round | pending_q;
    assign low_deck   = left_q < CARD_W'(RESHUF_THRESH);
    assign deck_empty = left_q == '0;
    assign tmo_hit    = tmo_q == TMO_W'(SHUF_TIMEOUT - 1);
    assign take       = (state_q == READY) && !(rnd && low_deck) && arb_valid && !deck_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = SHUF_REQ;
            SHUF_REQ:  state_d = SHUF_WAIT;
            SHUF_WAIT: begin
                if (shuf_done) begin
                    state_d = READY;
                end else if (tmo_hit) begin
                    state_d = SHUF_REQ;
                end
            end
            READY: begin
                if (rnd && low_deck) begin
                    state_d = SHUF_REQ;
                end else if (arb_valid) begin
                    state_d = deck_empty ? SHUF_REQ : FETCH;
                end
            end
            FETCH:     state_d = LOAD;
            LOAD:      state_d = DELIVER;
            DELIVER:   state_d = READY;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            left_q    <= '0;
            addr_q    <= '0;
            card_q    <= '0;
            tmo_q     <= '0;
            pending_q <= 1'b0;
            last_q    <= 1'(REQ_DEALER);
            winner_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // A round start seen while busy is held until the next READY cycle.
            if (state_q != READY && new_round) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                SHUF_REQ: tmo_q <= '0;
                SHUF_WAIT: begin
                    if (shuf_done) begin
                        ptr_q     <= '0;
                        left_q    <= CARD_W'(DECK_SIZE);
                        pending_q <= 1'b0;
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                READY: begin
                    if (rnd && !low_deck) begin
                        pending_q <= 1'b0;
                    end
                    if (take) begin
                        winner_q <= arb_winner;
                        addr_q   <= ptr_q;
                    end
                end
                LOAD: begin
                    card_q <= card_rd_data;
                    ptr_q  <= ptr_q + 1'b1;
                    left_q <= left_q - 1'b1;
                    last_q <= winner_q;
                end
                default: ;
            endcase
        end
    end

    assign grant      = (state_q == DELIVER) ? req_onehot(winner_q) : 2'b00;
    assign card_valid = state_q == DELIVER;
    assign card_out   = card_q;
    assign shuf_start = state_q == SHUF_REQ;
    assign card_addr  = addr_q;
    assign cards_left = left_q;
    assign ready      = state_q == READY;
    assign shuf_err   = err_q;

endmodule

// File: tb/tb_card_dealer_ctrl.sv
// Self-checking bench for card_dealer_ctrl: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model of the dealer.
module tb_card_dealer_ctrl;

    localparam int DK     = 52;
    localparam int THRESH = 15;
    localparam int TMO    = 1023;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_round = 1'b0;
    logic [1:0] req = 2'b00;
    logic       shuf_done = 1'b0;
    logic [5:0] card_rd_data = 6'd0;
    logic [1:0] grant;
    logic       card_valid, shuf_start, ready, shuf_err;
    logic [5:0] card_out, card_addr, cards_left;

    card_dealer_ctrl #(
        .DECK_SIZE     (DK),
        .RESHUF_THRESH (THRESH),
        .SHUF_TIMEOUT  (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .new_round    (new_round),
        .req          (req),
        .grant        (grant),
        .card_valid   (card_valid),
        .card_out     (card_out),
        .shuf_start   (shuf_start),
        .shuf_done    (shuf_done),
        .card_addr    (card_addr),
        .card_rd_data (card_rd_data),
        .cards_left   (cards_left),
        .ready        (ready),
        .shuf_err     (shuf_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Deck storage and shuffle engine environment
    int deck [DK];
    int n_shuffles = 0;

    function automatic void new_deck();
        if (n_shuffles == 0) begin
            for (int i = 0; i < DK; i++) deck[i] = (i + 10) % DK;
        end else begin
            for (int i = 0; i < DK; i++) deck[i] = i;
            for (int i = DK - 1; i > 0; i--) begin
                int j = int'($urandom_range(0, i));
                int t = deck[i];
                deck[i] = deck[j];
                deck[j] = t;
            end
        end
        n_shuffles++;
    endfunction

    initial for (int i = 0; i < DK; i++) deck[i] = i;

    always @(posedge clk) card_rd_data <= 6'(deck[int'(card_addr) % DK]);

    int cyc = 0;
    int done_cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (shuf_done) done_cyc = cyc;
    end

    // Transaction-level model of the dealer
    bit m_boot = 1'b1, m_start = 1'b0, m_shuf = 1'b0, m_pend = 1'b0, m_err = 1'b0;
    bit m_last = 1'b1, m_win = 1'b0;
    int m_wait = 0, m_phase = 0, m_ptr = 0, m_left = 0, m_card = 0, m_addr = 0, m_rd = 0;

    always @(posedge clk) begin
        int old_rd;
        bit rnd;
        old_rd = m_rd;
        m_rd   = deck[m_addr];
        if (rst) begin
            m_boot = 1'b1; m_start = 1'b0; m_shuf = 1'b0; m_phase = 0;
            m_ptr = 0; m_left = 0; m_last = 1'b1; m_pend = 1'b0; m_err = 1'b0;
            m_card = 0; m_addr = 0; m_win = 1'b0; m_wait = 0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_start = 1'b1;
            if (new_round) m_pend = 1'b1;
        end else if (m_start) begin
            m_start = 1'b0; m_shuf = 1'b1; m_wait = 0;
            if (new_round) m_pend = 1'b1;
        end else if (m_shuf) begin
            if (new_round) m_pend = 1'b1;
            if (shuf_done) begin
                m_shuf = 1'b0; m_left = DK; m_ptr = 0; m_pend = 1'b0;
            end else begin
                m_wait++;
                if (m_wait == TMO) begin
                    m_err = 1'b1; m_shuf = 1'b0; m_start = 1'b1;
                end
            end
        end else if (m_phase > 0) begin
            if (new_round) m_pend = 1'b1;
            if (m_phase == 2) begin
                m_card = old_rd; m_ptr++; m_left--; m_last = m_win;
            end
            m_phase--;
        end else begin
            rnd = new_round || m_pend;
            if (rnd && m_left < THRESH) begin
                m_start = 1'b1;
            end else begin
                if (rnd) m_pend = 1'b0;
                if (req != 2'b00) begin
                    if (m_left == 0) begin
                        m_start = 1'b1;
                    end else begin
                        m_win   = (req == 2'b11) ? !m_last : req[1];
                        m_addr  = m_ptr;
                        m_phase = 3;
                    end
                end
            end
        end
    end

    typedef struct {
        int cyc;
        int grant;
        int addr;
        int card;
    } vrec_t;

    vrec_t vq[$];
    int    sq[$];
    int    n_start = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("shuf_start", int'(shuf_start), int'(m_start));
                check("ready", int'(ready), int'(!(m_boot || m_start || m_shuf) && m_phase == 0));
                check("card_valid", int'(card_valid), int'(m_phase == 1));
                check("grant", int'(grant), (m_phase == 1) ? (m_win ? 2 : 1) : 0);
                check("card_out", int'(card_out), m_card);
                check("card_addr", int'(card_addr), m_addr);
                check("cards_left", int'(cards_left), m_left);
                check("shuf_err", int'(shuf_err), int'(m_err));
                if (shuf_start) begin
                    n_start++;
                    sq.push_back(cyc);
                end
                if (card_valid) vq.push_back('{cyc, int'(grant), int'(card_addr), int'(card_out)});
            end
        end
    end

    // Input driver: requesters, round pulses, reset and the shuffle engine
    int tok [2] = '{0, 0};
    bit rand_mode = 1'b0;
    bit shuf_en = 1'b1;
    int nr_req = 0;
    int rst_cnt = 3;
    int cd = 0;
    int rise_cyc = 0;

    initial begin
        forever begin
            logic [1:0] nreq;
            @(negedge clk);
            if (rst_cnt > 0) begin
                rst = 1'b1; rst_cnt--; tok[0] = 0; tok[1] = 0; cd = 0;
            end else begin
                rst = 1'b0;
            end
            new_round = (nr_req > 0) || (rand_mode && $urandom_range(0, 40) == 0);
            nr_req = 0;
            for (int i = 0; i < 2; i++) begin
                if (grant[i] && tok[i] > 0) tok[i]--;
                if (rand_mode && tok[i] == 0 && $urandom_range(0, 5) == 0)
                    tok[i] = 1 + int'($urandom_range(0, 1));
            end
            nreq = {tok[1] > 0, tok[0] > 0};
            if (nreq[0] && !req[0]) rise_cyc = cyc;
            req = nreq;
            shuf_done = 1'b0;
            if (shuf_start) begin
                cd = rand_mode ? int'($urandom_range(1, 12)) : 5;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0 && shuf_en) begin
                    shuf_done = 1'b1;
                    new_deck();
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input string name, input int budget);
        int k = 0;
        while (!(ready && tok[0] == 0 && tok[1] == 0) && k < budget) begin
            tick(1);
            k++;
        end
        check({name, "_bound"}, int'(k < budget), 1);
    endtask

    initial begin
        int n0, k, p;
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, k, p;
        tick(2);
        check("rst_ready", int'(ready), 0);
        check("rst_left", int'(cards_left), 0);
        check("rst_valid", int'(card_valid), 0);
        check("rst_start", int'(shuf_start), 0);
        check("rst_addr", int'(card_addr), 0);

        wait_ready("boot", 100);
        check("boot_starts", n_start, 1);
        check("boot_left", int'(cards_left), 52);

        vq.delete();
        tok[0] = 1;
        wait_ready("first_card", 100);
        check("first_count", vq.size(), 1);
        if (vq.size() == 1) begin
            check("first_card_out", vq[0].card, 10);
            check("first_grant", vq[0].grant, 1);
            check("first_latency", vq[0].cyc - rise_cyc, 3);
        end
        check("first_left", int'(cards_left), 51);

        tok[1] = 1;
        wait_ready("dealer_card", 100);
        vq.delete();
        tok[0] = 2;
        tok[1] = 2;
        wait_ready("alternate", 200);
        check("alt_count", vq.size(), 4);
        if (vq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("alt_grant", vq[i].grant, (i % 2 == 0) ? 1 : 2);
                check("alt_addr", vq[i].addr, 2 + i);
                if (i > 0) check("alt_spacing", vq[i].cyc - vq[i-1].cyc, 4);
            end
        end
        check("alt_left", int'(cards_left), 46);

        tok[0] = 32;
        wait_ready("deal_to_14", 400);
        check("left_14", int'(cards_left), 14);
        n0 = n_start;
        nr_req = 1;
        tick(3);
        check("reshuf_at_14", n_start, n0 + 1);
        wait_ready("reshuf_14_done", 100);
        check("reshuf_14_left", int'(cards_left), 52);

        tok[0] = 37;
        wait_ready("deal_to_15", 400);
        check("left_15", int'(cards_left), 15);
        n0 = n_start;
        nr_req = 1;
        tick(10);
        check("no_reshuf_at_15", n_start, n0);
        check("ready_at_15", int'(ready), 1);
        check("left_still_15", int'(cards_left), 15);

        tok[0] = 15;
        wait_ready("deal_all", 200);
        check("left_0", int'(cards_left), 0);
        n0 = n_start;
        vq.delete();
        tok[0] = 1;
        wait_ready("empty_req", 200);
        check("empty_reshuf", n_start, n0 + 1);
        check("empty_count", vq.size(), 1);
        if (vq.size() == 1) begin
            check("empty_addr", vq[0].addr, 0);
            check("empty_card", vq[0].card, deck[0]);
            check("empty_after_done", int'(vq[0].cyc > done_cyc), 1);
        end
        check("empty_left", int'(cards_left), 51);

        rand_mode = 1'b1;
        tick(4000);
        rand_mode = 1'b0;
        wait_ready("random_drain", 2000);

        check("err_before", int'(shuf_err), 0);
        shuf_en = 1'b0;
        n0 = n_start;
        rst_cnt = 2;
        k = 0;
        while (n_start < n0 + 2 && k < 1200) begin
            tick(1);
            k++;
        end
        check("tmo_bound", int'(k < 1200), 1);
        if (sq.size() >= 2) begin
            p = sq[sq.size()-1] - sq[sq.size()-2];
            check("tmo_period", int'(p >= TMO && p <= TMO + 2), 1);
        end
        check("tmo_err", int'(shuf_err), 1);
        shuf_en = 1'b1;
        wait_ready("tmo_recover", 100);
        check("err_sticky", int'(shuf_err), 1);
        check("tmo_left", int'(cards_left), 52);

        tok[0] = 1;
        tick(1);
        rst_cnt = 2;
        vq.delete();
        n0 = n_start;
        tick(2);
        check("midrst_valid", int'(card_valid), 0);
        check("midrst_ready", int'(ready), 0);
        check("midrst_left", int'(cards_left), 0);
        check("midrst_err", int'(shuf_err), 0);
        check("midrst_addr", int'(card_addr), 0);
        check("midrst_card", int'(card_out), 0);
        check("midrst_grant", int'(grant), 0);
        wait_ready("midrst_recover", 100);
        check("midrst_no_card", vq.size(), 0);
        check("midrst_reshuf", n_start, n0 + 1);
        check("midrst_left52", int'(cards_left), 52);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
